bmd_mwr_scheduler: RTL
======================

BMD_MWR_SCHEDULER -- requirements
Module: bmd_mwr_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4, number of DMA source channels (1..8).
REQ-002 Parameter ADDR_W, default 64, host byte address width.
REQ-003 Parameter LEN_W, default 16, job length field width in DW.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, with ports named as follows.
REQ-005 clk  in  1  TRN clock; all logic rising-edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 ch_req_i  in  NUM_CH  per-channel job request, level.
REQ-008 ch_addr_i  in  NUM_CH*ADDR_W  job host byte address; bits[1:0] ignored (DW aligned).
REQ-009 ch_len_i  in  NUM_CH*LEN_W  job length in DW.
REQ-010 ch_ack_o  out  NUM_CH  one-cycle pulse, job captured.
REQ-011 ch_done_o  out  NUM_CH  one-cycle pulse, all job descriptors accepted.
REQ-012 cfg_prg_max_payload_size  in  3  programmed MPS: 000=128B .. 101=4096B.
REQ-013 cfg_bus_mstr_enable  in  1  new grants allowed when 1.
REQ-014 cfg_to_turnoff_n  in  1  turnoff request, active low.
REQ-015 cfg_turnoff_ok_n  out  1  turnoff acknowledge, active low.
REQ-016 desc_valid_o / desc_ready_i  out/in  1/1  MWr descriptor handshake to TLP engine.
REQ-017 desc_addr_o  out  ADDR_W  descriptor byte address.
REQ-018 desc_len_o  out  11  descriptor length in DW, 1..1024.
REQ-019 desc_ch_o  out  3  source channel index.
REQ-020 desc_last_o  out  1  final descriptor of the job.
REQ-021 busy_o  out  1  high in any state other than IDLE.

Function
REQ-022 FSM states SHALL be IDLE, LOAD, CALC, ISSUE and DONE.
REQ-023 IDLE->LOAD SHALL occur when any ch_req_i is set, cfg_bus_mstr_enable=1 and no turnoff is pending; the grant is round-robin starting at last granted index+1, with pointer reset to channel 0.
REQ-024 LOAD SHALL capture the granted channel's addr/len, pulse its ch_ack_o, then go to DONE if len=0, else to CALC.
REQ-025 CALC SHALL compute chunk = min(remaining, mps_dw, DW to next 4 KB boundary), where mps_dw = 32<<mps and mps>101 clamps to 101 (1024 DW).
REQ-026 ISSUE SHALL hold desc_valid_o=1 with all desc_* fields stable until desc_ready_i=1.
REQ-027 On handshake, addr SHALL advance by chunk*4 and remaining SHALL decrement by chunk; the FSM then goes to CALC if remaining>0, else to DONE.
REQ-028 desc_last_o SHALL be 1 exactly when chunk equals remaining.
REQ-029 DONE SHALL pulse ch_done_o for the captured channel for one cycle, then return to IDLE.
REQ-030 Latency: request seen in IDLE at cycle N -> ack at N+1 -> desc_valid_o at N+3.
REQ-031 Dropping cfg_bus_mstr_enable mid-job SHALL NOT abort the job; it only blocks new grants.
REQ-032 A low cfg_to_turnoff_n SHALL latch turnoff pending; cfg_turnoff_ok_n goes 0 on the cycle after the FSM is in IDLE and stays 0 while cfg_to_turnoff_n=0.
REQ-033 cfg_to_turnoff_n returning to 1 SHALL clear the pending flag, with cfg_turnoff_ok_n=1 on the next cycle.
REQ-034 A channel whose ch_req_i stays high after ack SHALL be treated as a new job, eligible again only in round-robin order.
REQ-035 Address arithmetic SHALL be ADDR_W-bit modulo; the 4 KB split guarantees no descriptor crosses a 4 KB boundary.

Reset
REQ-036 While rst=1, asynchronously: FSM=IDLE, desc_valid_o=0, desc_* fields=0, ch_ack_o=0, ch_done_o=0, busy_o=0, cfg_turnoff_ok_n=1, RR pointer=0, turnoff pending cleared.
REQ-037 A reset mid-job SHALL discard the job with no ch_done_o pulse.

Verification
REQ-038 ch0 addr 0x1000, len 64, mps=000 -> descriptors (0x1000,32,last=0) then (0x1080,32,last=1), then ch_done_o[0].
REQ-039 ch1 addr 0x0FF0, len 16, mps=001 -> (0x0FF0,4,last=0) then (0x1000,12,last=1).
REQ-040 All four channels held requesting len=1 -> grant order 0,1,2,3,0 with one ack each.
REQ-041 desc_ready_i=0 for 5 cycles during ISSUE -> desc_valid_o and all desc_* fields unchanged, then a single handshake.
REQ-042 cfg_to_turnoff_n=0 during a 3-descriptor job -> cfg_turnoff_ok_n stays 1 until after DONE, then 0 in IDLE; no new ack while ch_req_i=1.
REQ-043 rst=1 asserted in ISSUE -> desc_valid_o=0 with no clock edge; no done pulse after release.

Source files
------------

// File: rtl/bmd_mwr_scheduler.sv
// Round-robin DMA job scheduler: splits per-channel memory-write jobs into
// MWr descriptors bounded by max payload size and 4 KB address boundaries.
module bmd_mwr_scheduler #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_req_i,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
    input  logic [NUM_CH*LEN_W-1:0]  ch_len_i,
    output logic [NUM_CH-1:0]        ch_ack_o,
    output logic [NUM_CH-1:0]        ch_done_o,
    input  logic [2:0]               cfg_prg_max_payload_size,
    input  logic                     cfg_bus_mstr_enable,
    input  logic                     cfg_to_turnoff_n,
    output logic                     cfg_turnoff_ok_n,
    output logic                     desc_valid_o,
    input  logic                     desc_ready_i,
    output logic [ADDR_W-1:0]        desc_addr_o,
    output logic [10:0]              desc_len_o,
    output logic [2:0]               desc_ch_o,
    output logic                     desc_last_o,
    output logic                     busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_ISSUE,
        S_DONE
    } state_t;

    localparam int CW = (LEN_W > 11) ? LEN_W : 11;

    state_t              state_q, state_d;
    logic [2:0]          grant_q, grant_d;
    logic [2:0]          rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [ADDR_W-1:0]   desc_addr_q, desc_addr_d;
    logic [10:0]         desc_len_q, desc_len_d;
    logic [2:0]          desc_ch_q, desc_ch_d;
    logic                desc_last_q, desc_last_d;
    logic                pending_q, pending_d;
    logic                ok_n_q, ok_n_d;

    logic                found_hi, found_lo;
    logic [2:0]          sel_hi, sel_lo, grant_sel;
    logic [ADDR_W-1:0]   load_addr;
    logic [LEN_W-1:0]    load_len;
    logic [2:0]          mps_clamp;
    logic [10:0]         mps_dw, bnd_dw, chunk;
    logic [CW-1:0]       rem_ext, chunk_ext;
    logic                chunk_is_last;
    logic [ADDR_W-1:0]   addr_next;
    logic [LEN_W-1:0]    rem_next;

    // Round-robin: first requester at or above the pointer, else wrap to the lowest.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (!found_hi && ch_req_i[j] && (3'(j) >= rr_ptr_q)) begin
                found_hi = 1'b1;
                sel_hi   = 3'(j);
            end
            if (!found_lo && ch_req_i[j]) begin
                found_lo = 1'b1;
                sel_lo   = 3'(j);
            end
        end
        grant_sel = found_hi ? sel_hi : sel_lo;
    end

    always_comb begin
        load_addr = '0;
        load_len  = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (grant_q == 3'(j)) begin
                load_addr = ch_addr_i[j*ADDR_W +: ADDR_W];
                load_len  = ch_len_i[j*LEN_W +: LEN_W];
            end
        end
    end

    // Chunk = min(remaining, payload limit, DWs left before the next 4 KB line).
    always_comb begin
        mps_clamp = (cfg_prg_max_payload_size > 3'd5) ? 3'd5 : cfg_prg_max_payload_size;
        mps_dw    = 11'd32 << mps_clamp;
        bnd_dw    = 11'd1024 - {1'b0, addr_q[11:2]};
        rem_ext   = CW'(rem_q);
        chunk_ext = rem_ext;
        if (CW'(mps_dw) < chunk_ext) begin
            chunk_ext = CW'(mps_dw);
        end
        if (CW'(bnd_dw) < chunk_ext) begin
            chunk_ext = CW'(bnd_dw);
        end
        chunk         = chunk_ext[10:0];
        chunk_is_last = (chunk_ext == rem_ext);
        addr_next     = addr_q + ADDR_W'({desc_len_q, 2'b00});
        rem_next      = LEN_W'(rem_ext - CW'(desc_len_q));
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        desc_addr_d = desc_addr_q;
        desc_len_d  = desc_len_q;
        desc_ch_d   = desc_ch_q;
        desc_last_d = desc_last_q;
        pending_d   = !cfg_to_turnoff_n;
        ok_n_d      = !(!cfg_to_turnoff_n && (state_q == S_IDLE));

        case (state_q)
            S_IDLE: begin
                if ((|ch_req_i) && cfg_bus_mstr_enable && !pending_q && cfg_to_turnoff_n) begin
                    grant_d  = grant_sel;
                    rr_ptr_d = (int'(grant_sel) == NUM_CH - 1) ? 3'd0 : grant_sel + 3'd1;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                addr_d  = load_addr & ~ADDR_W'(3);
                rem_d   = load_len;
                state_d = (load_len == '0) ? S_DONE : S_CALC;
            end
            S_CALC: begin
                desc_addr_d = addr_q;
                desc_len_d  = chunk;
                desc_last_d = chunk_is_last;
                desc_ch_d   = grant_q;
                state_d     = S_ISSUE;
            end
            S_ISSUE: begin
                if (desc_ready_i) begin
                    addr_d  = addr_next;
                    rem_d   = rem_next;
                    state_d = (rem_next == '0) ? S_DONE : S_CALC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            desc_addr_q <= '0;
            desc_len_q  <= '0;
            desc_ch_q   <= '0;
            desc_last_q <= 1'b0;
            pending_q   <= 1'b0;
            ok_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            desc_addr_q <= desc_addr_d;
            desc_len_q  <= desc_len_d;
            desc_ch_q   <= desc_ch_d;
            desc_last_q <= desc_last_d;
            pending_q   <= pending_d;
            ok_n_q      <= ok_n_d;
        end
    end

    always_comb begin
        ch_ack_o  = '0;
        ch_done_o = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (grant_q == 3'(j)) begin
                ch_ack_o[j]  = (state_q == S_LOAD);
                ch_done_o[j] = (state_q == S_DONE);
            end
        end
    end

    assign desc_valid_o     = (state_q == S_ISSUE);
    assign desc_addr_o      = desc_addr_q;
    assign desc_len_o       = desc_len_q;
    assign desc_ch_o        = desc_ch_q;
    assign desc_last_o      = desc_last_q;
    assign busy_o           = (state_q != S_IDLE);
    assign cfg_turnoff_ok_n = ok_n_q;

endmodule
